// File: rtl/flush_ctrl.sv
// ============================================================================
// flush_ctrl : 5-stage pipeline redirect/flush/stall sequencer
// Optional macro FLUSH_PERF_EN enables the accepted-redirect counter.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module flush_ctrl #(
   parameter int NSTAGE = 5,
   parameter int PC_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              exc_req_i,
   input  logic [PC_W-1:0]   exc_vector_i,
   input  logic              br_req_i,
   input  logic [PC_W-1:0]   br_target_i,
   input  logic              lu_stall_i,
   input  logic              hold_i,
   output logic              redirect_valid_o,
   output logic [PC_W-1:0]   redirect_pc_o,
   output logic [NSTAGE-1:0] stage_flush_o,
   output logic [NSTAGE-1:0] stage_stall_o,
   output logic              busy_o,
   output logic [15:0]       flush_cnt_o
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_DRAIN  = 1'b1;
   localparam logic       KIND_BR  = 1'b0;
   localparam logic       KIND_EXC = 1'b1;

   localparam logic [NSTAGE-1:0] MASK_BR      = NSTAGE'(5'b00011);
   localparam logic [NSTAGE-1:0] MASK_EXC     = NSTAGE'(5'b00111);
   localparam logic [NSTAGE-1:0] STALL_LU     = NSTAGE'(5'b00011);
   localparam logic [NSTAGE-1:0] FLUSH_BUBBLE = NSTAGE'(5'b00100);

   logic [0:0]        state_q, state_d;
   logic              kind_q, kind_d;
   logic [NSTAGE-1:0] mask_q, mask_d;
   logic              rv_q, rv_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              take_exc, take_br, accept;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         kind_q  <= KIND_BR;
         mask_q  <= '0;
         rv_q    <= 1'b0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         mask_q  <= mask_d;
         rv_q    <= rv_d;
         pc_q    <= pc_d;
      end
   end

   // Next-state: everything freezes under hold, so a pending pulse survives it
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      mask_d   = mask_q;
      rv_d     = rv_q;
      pc_d     = pc_q;
      take_exc = 1'b0;
      take_br  = 1'b0;
      if (!hold_i) begin
         rv_d = 1'b0;
         if (state_q == S_IDLE) begin
            take_exc = exc_req_i;
            take_br  = br_req_i & ~exc_req_i;
         end else begin
            // Only an exception may preempt a branch drain; other requests are wrong-path
            take_exc = exc_req_i & (kind_q == KIND_BR);
            mask_d   = mask_q >> 1;
            if ((mask_q >> 1) == '0) begin
               state_d = S_IDLE;
            end
         end
         if (take_exc) begin
            state_d = S_DRAIN;
            kind_d  = KIND_EXC;
            mask_d  = MASK_EXC;
            rv_d    = 1'b1;
            pc_d    = exc_vector_i;
         end else if (take_br) begin
            state_d = S_DRAIN;
            kind_d  = KIND_BR;
            mask_d  = MASK_BR;
            rv_d    = 1'b1;
            pc_d    = br_target_i;
         end
      end
      accept = take_exc | take_br;
   end

   // Outputs
   always_comb begin
      stage_flush_o = '0;
      stage_stall_o = '0;
      if (hold_i) begin
         stage_stall_o = '1;
      end else if (state_q == S_DRAIN) begin
         stage_flush_o = mask_q;
      end else if (lu_stall_i && !accept) begin
         stage_stall_o = STALL_LU;
         stage_flush_o = FLUSH_BUBBLE;
      end
   end

   assign redirect_valid_o = rv_q & ~hold_i;
   assign redirect_pc_o    = pc_q;
   assign busy_o           = (state_q == S_DRAIN);

`ifdef FLUSH_PERF_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign flush_cnt_o = cnt_q;
`else
   assign flush_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_flush_ctrl.sv
// ============================================================================
// tb_flush_ctrl : directed self-checking bench for flush_ctrl
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_flush_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        exc_req_i = 1'b0;
   logic [31:0] exc_vector_i = '0;
   logic        br_req_i = 1'b0;
   logic [31:0] br_target_i = '0;
   logic        lu_stall_i = 1'b0;
   logic        hold_i = 1'b0;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic [4:0]  stage_flush_o;
   logic [4:0]  stage_stall_o;
   logic        busy_o;
   logic [15:0] flush_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   // {valid, pc, flush, stall, busy}
   logic [43:0] obs;
   assign obs = {redirect_valid_o, redirect_pc_o, stage_flush_o, stage_stall_o, busy_o};

   flush_ctrl #(.NSTAGE(5), .PC_W(32)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .exc_req_i        (exc_req_i),
      .exc_vector_i     (exc_vector_i),
      .br_req_i         (br_req_i),
      .br_target_i      (br_target_i),
      .lu_stall_i       (lu_stall_i),
      .hold_i           (hold_i),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .stage_flush_o    (stage_flush_o),
      .stage_stall_o    (stage_stall_o),
      .busy_o           (busy_o),
      .flush_cnt_o      (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 44'h0) begin
         n_err++;
         $display("FAIL reset_outputs got %h exp %h", obs, 44'h0);
      end
      n_cmp++;
      if (flush_cnt_o !== 16'h0) begin
         n_err++;
         $display("FAIL reset_cnt got %h exp %h", flush_cnt_o, 16'h0);
      end
      tick();
      tick();
      #2 rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_branch();
      br_req_i = 1'b1; br_target_i = 32'h0000_0100;
      tick();
      br_req_i = 1'b0;
      #1;
      n_cmp++;
      if (obs !== {1'b1, 32'h100, 5'b00011, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL br_cycle1 got %h exp %h", obs, {1'b1, 32'h100, 5'b00011, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (obs !== {1'b0, 32'h100, 5'b00001, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL br_cycle2 got %h exp %h", obs, {1'b0, 32'h100, 5'b00001, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (obs !== {1'b0, 32'h100, 5'b00000, 5'b00000, 1'b0}) begin
         n_err++;
         $display("FAIL br_idle got %h exp %h", obs, {1'b0, 32'h100, 5'b00000, 5'b00000, 1'b0});
      end
   endtask

   task automatic test_exc_priority();
      exc_req_i = 1'b1; exc_vector_i = 32'h0000_0080;
      br_req_i  = 1'b1; br_target_i  = 32'h0000_0200;
      tick();
      exc_req_i = 1'b0; br_req_i = 1'b0;
      #1;
      n_cmp++;
      if (obs !== {1'b1, 32'h80, 5'b00111, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL exc_cycle1 got %h exp %h", obs, {1'b1, 32'h80, 5'b00111, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (obs !== {1'b0, 32'h80, 5'b00011, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL exc_cycle2 got %h exp %h", obs, {1'b0, 32'h80, 5'b00011, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (obs !== {1'b0, 32'h80, 5'b00001, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL exc_cycle3 got %h exp %h", obs, {1'b0, 32'h80, 5'b00001, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (obs !== {1'b0, 32'h80, 5'b00000, 5'b00000, 1'b0}) begin
         n_err++;
         $display("FAIL exc_idle got %h exp %h", obs, {1'b0, 32'h80, 5'b00000, 5'b00000, 1'b0});
      end
   endtask

   task automatic test_preempt();
      br_req_i = 1'b1; br_target_i = 32'h0000_0300;
      tick();
      br_req_i = 1'b0;
      tick();
      exc_req_i = 1'b1; exc_vector_i = 32'h0000_0080;
      #1;
      n_cmp++;
      if (obs !== {1'b0, 32'h300, 5'b00001, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL pre_br2 got %h exp %h", obs, {1'b0, 32'h300, 5'b00001, 5'b00000, 1'b1});
      end
      tick();
      exc_req_i = 1'b0;
      #1;
      n_cmp++;
      if (obs !== {1'b1, 32'h80, 5'b00111, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL pre_exc1 got %h exp %h", obs, {1'b1, 32'h80, 5'b00111, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (obs !== {1'b0, 32'h80, 5'b00011, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL pre_exc2 got %h exp %h", obs, {1'b0, 32'h80, 5'b00011, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (obs !== {1'b0, 32'h80, 5'b00001, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL pre_exc3 got %h exp %h", obs, {1'b0, 32'h80, 5'b00001, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL pre_idle busy got %b exp %b", busy_o, 1'b0);
      end
   endtask

   task automatic test_load_use();
      lu_stall_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if ({stage_stall_o, stage_flush_o, busy_o} !== {5'b00011, 5'b00100, 1'b0}) begin
            n_err++;
            $display("FAIL lu_idle%0d got %h exp %h", i, {stage_stall_o, stage_flush_o, busy_o},
                     {5'b00011, 5'b00100, 1'b0});
         end
         tick();
      end
      br_req_i = 1'b1; br_target_i = 32'h0000_0400;
      #1;
      n_cmp++;
      if ({stage_stall_o, stage_flush_o} !== 10'h0) begin
         n_err++;
         $display("FAIL lu_vs_accept got %h exp %h", {stage_stall_o, stage_flush_o}, 10'h0);
      end
      tick();
      br_req_i = 1'b0;
      #1;
      n_cmp++;
      if (obs !== {1'b1, 32'h400, 5'b00011, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL lu_drain got %h exp %h", obs, {1'b1, 32'h400, 5'b00011, 5'b00000, 1'b1});
      end
      tick();
      tick();
      n_cmp++;
      if ({stage_stall_o, stage_flush_o, busy_o} !== {5'b00011, 5'b00100, 1'b0}) begin
         n_err++;
         $display("FAIL lu_after got %h exp %h", {stage_stall_o, stage_flush_o, busy_o},
                  {5'b00011, 5'b00100, 1'b0});
      end
      lu_stall_i = 1'b0;
   endtask

   task automatic test_hold();
      hold_i = 1'b1; br_req_i = 1'b1; br_target_i = 32'h0000_0500;
      tick();
      n_cmp++;
      if ({busy_o, redirect_valid_o, stage_stall_o} !== {1'b0, 1'b0, 5'b11111}) begin
         n_err++;
         $display("FAIL hold_no_accept got %h exp %h", {busy_o, redirect_valid_o, stage_stall_o},
                  {1'b0, 1'b0, 5'b11111});
      end
      hold_i = 1'b0;
      tick();
      br_req_i = 1'b0;
      tick();
      hold_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (obs !== {1'b0, 32'h500, 5'b00000, 5'b11111, 1'b1}) begin
            n_err++;
            $display("FAIL hold_mid%0d got %h exp %h", i, obs, {1'b0, 32'h500, 5'b00000, 5'b11111, 1'b1});
         end
         tick();
      end
      hold_i = 1'b0;
      #1;
      n_cmp++;
      if (obs !== {1'b0, 32'h500, 5'b00001, 5'b00000, 1'b1}) begin
         n_err++;
         $display("FAIL hold_release got %h exp %h", obs, {1'b0, 32'h500, 5'b00001, 5'b00000, 1'b1});
      end
      tick();
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL hold_idle busy got %b exp %b", busy_o, 1'b0);
      end
   endtask

   task automatic test_async_reset_cnt();
      logic [15:0] exp_cnt;
`ifdef FLUSH_PERF_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif
      #2 rst_ni = 1'b0;
      #2 rst_ni = 1'b1;
      tick();
      br_req_i = 1'b1; br_target_i = 32'h0000_0600;
      tick();
      br_req_i = 1'b0;
      tick();
      tick();
      br_req_i = 1'b1;
      tick();
      br_req_i = 1'b0; exc_req_i = 1'b1; exc_vector_i = 32'h0000_0080;
      tick();
      exc_req_i = 1'b0;
      tick();
      n_cmp++;
      if (flush_cnt_o !== exp_cnt) begin
         n_err++;
         $display("FAIL cnt_before_reset got %0d exp %0d", flush_cnt_o, exp_cnt);
      end
      n_cmp++;
      if (busy_o !== 1'b1 || stage_flush_o !== 5'b00011) begin
         n_err++;
         $display("FAIL mid_drain got busy %b flush %b exp busy 1 flush 00011", busy_o, stage_flush_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      n_cmp++;
      if ({obs, flush_cnt_o} !== 60'h0) begin
         n_err++;
         $display("FAIL async_reset got %h exp %h", {obs, flush_cnt_o}, 60'h0);
      end
      #2 rst_ni = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_branch();
      test_exc_priority();
      test_preempt();
      test_load_use();
      test_hold();
      test_async_reset_cnt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
